// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: instruction fetch sequencer with pair select, RVC classification and valid/ready output.
// Optional SKIP_ZERO_EN: all-zero words are skipped instead of presented.
module im_fetch_ctrl #(
  parameter int ADDR_W = 6,
  parameter int END_PC = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-2:0] im_sel,
  input  logic [63:0]       im_ir,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_is_c,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;
  localparam logic [ADDR_W:0] END_W = (ADDR_W+1)'(END_PC);
  state_t state, state_n;
  logic [ADDR_W:0] pc, pc_n;
  logic first, first_n, valid_n, is_c_n;
  logic [31:0] instr_n, word;
  logic [ADDR_W-1:0] ipc_n;
  logic word_c, slot_free, at_end, skip, redirect_hi;
  assign im_sel = pc[ADDR_W-1:1];
  assign word = pc[0] ? im_ir[31:0] : im_ir[63:32];
  assign word_c = word[1:0] != 2'b11;
  assign slot_free = !instr_valid || instr_ready;
  assign at_end = pc == END_W;
  assign redirect_hi = {1'b0, redirect_pc} > END_W;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == HALT;
`ifdef SKIP_ZERO_EN
  assign skip = word == 32'h0;
`else
  assign skip = 1'b0;
`endif
  // The first RUN cycle after start only primes the pipeline; skips may still advance pc there.
  always_comb begin
    state_n = state;
    pc_n = pc;
    first_n = first;
    valid_n = instr_valid;
    instr_n = instr;
    ipc_n = instr_pc;
    is_c_n = instr_is_c;
    if (redirect_valid && state != IDLE) begin
      valid_n = 1'b0;
      first_n = 1'b0;
      pc_n = {1'b0, redirect_pc};
      state_n = redirect_hi ? HALT : RUN;
    end else if (state == IDLE || state == HALT) begin
      if (start) begin
        state_n = RUN;
        pc_n = '0;
        first_n = 1'b1;
      end
    end else if (state == DRAIN) begin
      if (slot_free) begin
        valid_n = 1'b0;
        state_n = HALT;
      end
    end else if (skip) begin
      pc_n = pc + 1'b1;
      first_n = 1'b0;
      valid_n = instr_valid && !instr_ready;
      state_n = at_end ? DRAIN : RUN;
    end else if (first) begin
      first_n = 1'b0;
    end else if (slot_free) begin
      valid_n = 1'b1;
      instr_n = word_c ? {16'h0, word[15:0]} : word;
      is_c_n = word_c;
      ipc_n = pc[ADDR_W-1:0];
      pc_n = pc + 1'b1;
      state_n = at_end ? DRAIN : RUN;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc <= '0;
      first <= 1'b0;
      instr_valid <= 1'b0;
      instr <= '0;
      instr_pc <= '0;
      instr_is_c <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      first <= first_n;
      instr_valid <= valid_n;
      instr <= instr_n;
      instr_pc <= ipc_n;
      instr_is_c <= is_c_n;
    end
  end
endmodule

// File: tb/tb_im_fetch_ctrl.sv
// tb_im_fetch_ctrl: vector table plus handshake scoreboard for im_fetch_ctrl.
module tb_im_fetch_ctrl;
  logic clk = 0, reset = 0, start = 0, instr_ready = 1, redirect_valid = 0;
  logic [5:0] redirect_pc = '0;
  logic [4:0] im_sel, sel40;
  logic [63:0] im_ir, ir40;
  logic instr_valid, instr_is_c, busy, done;
  logic [31:0] instr;
  logic [5:0] instr_pc;
  logic v40, c40, busy40, done40;
  logic [31:0] i40;
  logic [5:0] pc40;
  logic [31:0] mem [64];
  int n_vec = 0, n_err = 0;
  logic [5:0] exp_q [$];
  typedef struct {logic rdy; logic v; logic [5:0] pc; logic [4:0] sel;} vec_t;
  vec_t tbl [$];

  always #5 clk = ~clk;
  assign im_ir = {mem[{im_sel, 1'b0}], mem[{im_sel, 1'b1}]};
  assign ir40 = {mem[{sel40, 1'b0}], mem[{sel40, 1'b1}]};

  im_fetch_ctrl #(.ADDR_W(6), .END_PC(63)) dut (
    .clk(clk), .reset(reset), .start(start), .im_sel(im_sel), .im_ir(im_ir),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_is_c(instr_is_c), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy), .done(done));
  im_fetch_ctrl #(.ADDR_W(6), .END_PC(40)) u40 (
    .clk(clk), .reset(reset), .start(start), .im_sel(sel40), .im_ir(ir40),
    .instr_valid(v40), .instr_ready(instr_ready), .instr(i40),
    .instr_pc(pc40), .instr_is_c(c40), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy40), .done(done40));

  function automatic logic exp_c(int p);
    logic [31:0] w;
    w = mem[p];
    return w[1:0] != 2'b11;
  endfunction
  function automatic logic [31:0] exp_instr(int p);
    logic [31:0] w;
    w = mem[p];
    return exp_c(p) ? {16'h0, w[15:0]} : w;
  endfunction
  function automatic vec_t mk(logic r, logic v, int pc, int sel);
    vec_t t;
    t.rdy = r; t.v = v; t.pc = 6'(pc); t.sel = 5'(sel);
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(int budget);
    int k = 0;
    while (!instr_valid && k < budget) begin step(); k++; end
    chk("wait_valid", 32'(instr_valid), 1);
  endtask

  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got pc %0d, required no handshake", instr_pc);
      end else begin
        logic [5:0] p;
        p = exp_q.pop_front();
        chk("sb_pc", 32'(instr_pc), 32'(p));
        chk("sb_instr", instr, exp_instr(int'(p)));
        chk("sb_is_c", 32'(instr_is_c), 32'(exp_c(int'(p))));
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 + (i << 7);
    mem[0] = 32'h0; mem[1] = 32'h0000_40F9; mem[2] = 32'h0; mem[3] = 32'h0000_5159;
    mem[12] = 32'h41C2_5093;
`ifdef SKIP_ZERO_EN
    tbl.push_back(mk(1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 3, 2));
    exp_q.push_back(6'd1);
    for (int i = 3; i < 64; i++) exp_q.push_back(6'(i));
`else
    tbl.push_back(mk(1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 2, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 2, 1));
    tbl.push_back(mk(1, 1, 2, 1));
    tbl.push_back(mk(1, 1, 3, 2));
    for (int i = 0; i < 64; i++) exp_q.push_back(6'(i));
`endif
    #1;
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pc", 32'(instr_pc), 0);
    chk("rst_sel", 32'(im_sel), 0);
    step(); step();
    reset = 1;
    step();
    chk("idle_busy", 32'(busy), 0);
    start = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      step();
      start = 0;
      chk("tbl_valid", 32'(instr_valid), 32'(tbl[i].v));
      chk("tbl_sel", 32'(im_sel), 32'(tbl[i].sel));
      if (tbl[i].v) chk("tbl_pc", 32'(instr_pc), 32'(tbl[i].pc));
      if (i > 0) chk("tbl_busy", 32'(busy), 1);
      instr_ready = tbl[i].rdy;
    end
    begin
      int k = 0;
      while (!done && k < 100) begin step(); k++; end
    end
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_valid", 32'(instr_valid), 0);
    chk("end_sb_empty", exp_q.size(), 0);
    instr_ready = 0;
    start = 1;
    step();
    start = 0;
    wait_valid(10);
`ifdef SKIP_ZERO_EN
    chk("restart_pc", 32'(instr_pc), 1);
`else
    chk("restart_pc", 32'(instr_pc), 0);
`endif
    redirect_valid = 1; redirect_pc = 6'd12;
    step();
    redirect_valid = 0;
    chk("redir_flush_valid", 32'(instr_valid), 0);
    step();
    chk("redir_valid", 32'(instr_valid), 1);
    chk("redir_instr", instr, 32'h41C2_5093);
    chk("redir_is_c", 32'(instr_is_c), 0);
    chk("redir_pc", 32'(instr_pc), 12);
    redirect_valid = 1; redirect_pc = 6'd63;
    step();
    redirect_valid = 0;
    chk("r63_valid", 32'(instr_valid), 0);
    chk("r63_busy", 32'(busy), 1);
    chk("r63_end40_done", 32'(done40), 1);
    chk("r63_end40_valid", 32'(v40), 0);
    step();
    chk("r63_load_valid", 32'(instr_valid), 1);
    chk("r63_load_pc", 32'(instr_pc), 63);
    exp_q.push_back(6'd63);
    instr_ready = 1;
    step();
    chk("r63_done", 32'(done), 1);
    chk("r63_halt_busy", 32'(busy), 0);
    chk("r63_halt_valid", 32'(instr_valid), 0);
    chk("r63_sb_empty", exp_q.size(), 0);
    instr_ready = 0;
    start = 1;
    step();
    start = 0;
    wait_valid(10);
    #2;
    reset = 0;
    #1;
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_instr", instr, 0);
    chk("arst_pc", 32'(instr_pc), 0);
    chk("arst_busy", 32'(busy), 0);
    step();
    reset = 1;
    instr_ready = 1;
    redirect_valid = 1; redirect_pc = 6'd5;
    step();
    redirect_valid = 0;
    chk("idle_redir_busy", 32'(busy), 0);
    step(); step();
    chk("post_rst_valid", 32'(instr_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_done", 32'(done), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
